// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text arbiter and lcd_send_text.
// Optional feature macro used by this slice: LCD_ARB_PRIORITY_EN.
package lcd_pkg;

    localparam int LCD_LINE_LENGTH = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LATCH     = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } arb_state_t;

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin winner search starting at rr_ptr_i.
// With LCD_ARB_PRIORITY_EN defined, client 0 overrides the rotation.
module lcd_rr_picker #(
    parameter int N_CLIENTS = 4,
    parameter int IDX_W     = $clog2(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] req_i,
    input  logic [IDX_W-1:0]     rr_ptr_i,
    output logic [IDX_W-1:0]     winner_o,
    output logic                 valid_o
);

    logic [N_CLIENTS-1:0] req_m_s;
    logic [IDX_W:0]       pos_s;
    logic [IDX_W-1:0]     win_s;
    logic                 found_s;

    // First requester at or after the pointer, wrapping modulo N_CLIENTS
    always_comb begin
        req_m_s = req_i;
        win_s   = '0;
        found_s = 1'b0;
        pos_s   = '0;
`ifdef LCD_ARB_PRIORITY_EN
        if (req_i[0]) begin
            win_s   = '0;
            found_s = 1'b1;
        end else begin
            found_s = 1'b0;
        end
        req_m_s[0] = 1'b0;
`endif
        for (int i = 0; i < N_CLIENTS; i++) begin
            pos_s = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
            if (pos_s >= (IDX_W+1)'(N_CLIENTS)) begin
                pos_s = pos_s - (IDX_W+1)'(N_CLIENTS);
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && (|(req_m_s & (N_CLIENTS'(1) << pos_s)))) begin
                win_s   = IDX_W'(pos_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign winner_o = win_s;
    assign valid_o  = found_s;

endmodule

// File: rtl/lcd_text_arbiter.sv
// Round-robin arbiter sharing one lcd_send_text between N_CLIENTS text writers.
// Define LCD_ARB_PRIORITY_EN to make client 0 a strict high-priority requester.
module lcd_text_arbiter
    import lcd_pkg::*;
#(
    parameter int N_CLIENTS      = 4,
    parameter int LINE_LENGTH    = LCD_LINE_LENGTH,
    parameter int MIN_GAP_CYCLES = 1000
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [N_CLIENTS-1:0]               req,
    input  logic [N_CLIENTS*8*LINE_LENGTH-1:0] line1_in,
    input  logic [N_CLIENTS*8*LINE_LENGTH-1:0] line2_in,
    output logic [N_CLIENTS-1:0]               done,
    output logic                               busy,
    output logic [$clog2(N_CLIENTS)-1:0]       grant_id,
    output logic                               sendText,
    output logic [8*LINE_LENGTH-1:0]           line1,
    output logic [8*LINE_LENGTH-1:0]           line2,
    input  logic                               sendingDone
);

    localparam int IDX_W  = $clog2(N_CLIENTS);
    localparam int LINE_W = 8 * LINE_LENGTH;
    localparam int GAP_W  = (MIN_GAP_CYCLES > 0) ? $clog2(MIN_GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (MIN_GAP_CYCLES > 0) ? GAP_W'(MIN_GAP_CYCLES - 1) : {GAP_W{1'b0}};

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    hold_q, hold_d;
    logic [LINE_W-1:0]       line1_q, line1_d;
    logic [LINE_W-1:0]       line2_q, line2_d;
    logic                    send_q, send_d;
    logic [N_CLIENTS-1:0]    done_q, done_d;
    logic                    busy_q, busy_d;
    logic [IDX_W-1:0]        win_s;
    logic                    valid_s;
    logic [IDX_W-1:0]        next_ptr_s;

    lcd_rr_picker #(
        .N_CLIENTS (N_CLIENTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (win_s),
        .valid_o  (valid_s)
    );

    // Pointer value that puts the just-served client at lowest priority
    always_comb begin
        if (grant_q == IDX_W'(N_CLIENTS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_q + IDX_W'(1);
        end
    end

    // Next-state logic; hold_q blocks sampling for one IDLE cycle after a
    // transfer so the served client has time to drop req after its done pulse
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        gap_d    = gap_q;
        hold_d   = hold_q;
        line1_d  = line1_q;
        line2_d  = line2_q;
        send_d   = 1'b0;
        done_d   = '0;
        case (state_q)
            IDLE: begin
                hold_d = 1'b0;
                if (valid_s && !hold_q) begin
                    grant_d = win_s;
                    state_d = LATCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LATCH: begin
                line1_d = line1_in[grant_q*LINE_W +: LINE_W];
                line2_d = line2_in[grant_q*LINE_W +: LINE_W];
                send_d  = 1'b1;
                state_d = START;
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (sendingDone) begin
                    done_d = N_CLIENTS'(1) << grant_q;
`ifdef LCD_ARB_PRIORITY_EN
                    if (grant_q == '0) begin
                        rr_ptr_d = rr_ptr_q;
                    end else begin
                        rr_ptr_d = next_ptr_s;
                    end
`else
                    rr_ptr_d = next_ptr_s;
`endif
                    if (MIN_GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                    hold_d  = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            gap_q    <= '0;
            hold_q   <= 1'b0;
            line1_q  <= '0;
            line2_q  <= '0;
            send_q   <= 1'b0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            gap_q    <= gap_d;
            hold_q   <= hold_d;
            line1_q  <= line1_d;
            line2_q  <= line2_d;
            send_q   <= send_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign done     = done_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign sendText = send_q;
    assign line1    = line1_q;
    assign line2    = line2_q;

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Directed self-checking bench for lcd_text_arbiter (gap 10 and gap 0 instances).
module tb_lcd_text_arbiter;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [3:0]   req, req0;
    logic [511:0] l1, l2;
    logic         sd, sd0;
    logic [3:0]   done, done0;
    logic         busy, busy0;
    logic [1:0]   grant_id, grant0;
    logic         sendText, send0;
    logic [127:0] line1, line2, line1_0, line2_0;

    int errors = 0;
    int checks = 0;
    logic [1:0]   exp_g;
    logic [7:0]   ch;

    always #5 CLK = ~CLK;

    lcd_text_arbiter #(.N_CLIENTS(4), .LINE_LENGTH(16), .MIN_GAP_CYCLES(10)) dut (
        .CLK(CLK), .RESET(RESET), .req(req), .line1_in(l1), .line2_in(l2),
        .done(done), .busy(busy), .grant_id(grant_id), .sendText(sendText),
        .line1(line1), .line2(line2), .sendingDone(sd)
    );

    lcd_text_arbiter #(.N_CLIENTS(4), .LINE_LENGTH(16), .MIN_GAP_CYCLES(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .req(req0), .line1_in(l1), .line2_in(l2),
        .done(done0), .busy(busy0), .grant_id(grant0), .sendText(send0),
        .line1(line1_0), .line2(line2_0), .sendingDone(sd0)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
    endtask

    initial begin
        req = '0; req0 = '0; sd = 1'b0; sd0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ch = 8'h41 + 8'(i);
            l1[i*128 +: 128] = {16{ch}};
            ch = 8'h61 + 8'(i);
            l2[i*128 +: 128] = {16{ch}};
        end
        l1[128 +: 128] = "HELLO WORLD 1234";

        // reset state
        #1 RESET = 1'b1;
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_grant", 128'(grant_id), 128'd0);
        check("rst_send", 128'(sendText), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_line1", line1, 128'd0);
        check("rst_line2", line2, 128'd0);
        tick();
        tick();
        RESET = 1'b0;
        tick();

        // spurious sendingDone in IDLE
        sd = 1'b1;
        tick();
        sd = 1'b0;
        check("idle_spur_done", 128'(done), 128'd0);
        check("idle_spur_busy", 128'(busy), 128'd0);
        tick();

        // single request from client 1, sendingDone 50 cycles after sendText
        req = 4'b0010;
        tick();
        check("single_grant", 128'(grant_id), 128'd1);
        check("single_busy", 128'(busy), 128'd1);
        check("single_send_early", 128'(sendText), 128'd0);
        tick();
        check("single_send", 128'(sendText), 128'd1);
        check("single_line1", line1, "HELLO WORLD 1234");
        check("single_line2", line2, {16{8'h62}});
        tick();
        check("single_send_once", 128'(sendText), 128'd0);
        l1[128 +: 128] = "CHANGED CONTENTS";
        repeat (48) tick();
        check("snapshot_wait", line1, "HELLO WORLD 1234");
        tick();
        sd = 1'b1;
        req = 4'b0000;
        check("single_done_early", 128'(done), 128'd0);
        tick();
        sd = 1'b0;
        check("single_done", 128'(done), 128'h2);
        check("single_busy_gap", 128'(busy), 128'd1);
        tick();
        check("single_done_pulse", 128'(done), 128'd0);
        repeat (3) tick();
        sd = 1'b1;
        tick();
        sd = 1'b0;
        check("gap_spur_done", 128'(done), 128'd0);
        check("gap_spur_busy", 128'(busy), 128'd1);
        repeat (4) tick();
        check("gap_busy_last", 128'(busy), 128'd1);
        tick();
        check("gap_busy_fall", 128'(busy), 128'd0);
        check("snapshot_after", line1, "HELLO WORLD 1234");
        l1[128 +: 128] = {16{8'h42}};

        // fairness with all four requesting, gap of 10 between transfers
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
`ifdef LCD_ARB_PRIORITY_EN
            exp_g = 2'd0;
`else
            exp_g = 2'(k);
`endif
            tick();
            check($sformatf("fair%0d_grant", k), 128'(grant_id), 128'(exp_g));
            check($sformatf("fair%0d_send_pre", k), 128'(sendText), 128'd0);
            tick();
            check($sformatf("fair%0d_send", k), 128'(sendText), 128'd1);
            ch = 8'h41 + 8'(exp_g);
            check($sformatf("fair%0d_line1", k), line1, {16{ch}});
            tick();
            tick();
            sd = 1'b1;
            tick();
            sd = 1'b0;
            check($sformatf("fair%0d_done", k), 128'(done), 128'(4'b0001 << exp_g));
            repeat (11) tick();
        end
        req = 4'b0000;

        // zero-gap instance: 3 cycles from done to the next sendText
        req0 = 4'b0011;
        tick();
        check("gap0_grant_a", 128'(grant0), 128'd0);
        tick();
        check("gap0_send_a", 128'(send0), 128'd1);
        tick();
        tick();
        sd0 = 1'b1;
        tick();
        sd0 = 1'b0;
        check("gap0_done_a", 128'(done0), 128'h1);
        check("gap0_busy_fall", 128'(busy0), 128'd0);
        tick();
        check("gap0_send_m2", 128'(send0), 128'd0);
        tick();
        check("gap0_grant_b", 128'(grant0), 128'd1);
        check("gap0_send_m3", 128'(send0), 128'd0);
        tick();
        check("gap0_send_b", 128'(send0), 128'd1);
        req0 = 4'b0000;
        tick();
        tick();
        sd0 = 1'b1;
        tick();
        sd0 = 1'b0;
        check("gap0_done_b", 128'(done0), 128'h2);

        // reset during WAIT_DONE
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        tick();
        check("midrst_busy_pre", 128'(busy), 128'd1);
        RESET = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_grant", 128'(grant_id), 128'd0);
        check("midrst_line1", line1, 128'd0);
        check("midrst_send", 128'(sendText), 128'd0);
        sd = 1'b1;
        req = 4'b0100;
        tick();
        sd = 1'b0;
        RESET = 1'b0;
        check("midrst_no_done", 128'(done), 128'd0);
        tick();
        check("midrst_grant2", 128'(grant_id), 128'd2);
        check("midrst_busy2", 128'(busy), 128'd1);
        check("midrst_done2", 128'(done), 128'd0);
        tick();
        check("midrst_send2", 128'(sendText), 128'd1);
        check("midrst_line1_2", line1, {16{8'h43}});
        req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
